left_shift_normalizer: RTL and testbench

//  Iterative post-multiply normalizer for the fp_multiplier datapath.
//  - Left-shifts an unnormalized 48-bit mantissa one bit per cycle until the leading 1 reaches
//    bit 47, decrementing the biased exponent once per shift.
//  - Emits the 23-bit fraction, the adjusted exponent and the total shift amount.
//  - Counterpart of the right-shift alignment path; valid/ready handshake on both sides.

---
 rtl/left_shift_normalizer.sv | 143 ++++++++++++++
 tb/tb_left_shift_normalizer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/left_shift_normalizer.sv
`default_nettype none
// ---- left_shift_normalizer: iterative leading-one normalizer, one left shift per cycle ----
// ---- rev 1.0 ---------------------------------------------------------------------------

module left_shift_normalizer #(
  parameter int WIDTH  = 48,
  parameter int FRAC_W = 23,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  mant_in,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC_W-1:0] frac_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [7:0]        shift_amt,
  output logic              zero,
  output logic              subnormal
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [EXP_W-1:0]   e_q, e_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [FRAC_W-1:0]  frac_out_q, frac_out_d;
  logic [EXP_W-1:0]   exp_out_q, exp_out_d;
  logic [7:0]         shift_amt_q, shift_amt_d;
  logic               zero_q, zero_d;
  logic               subnormal_q, subnormal_d;

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    e_d         = e_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    frac_out_d  = frac_out_q;
    exp_out_d   = exp_out_q;
    shift_amt_d = shift_amt_q;
    zero_d      = zero_q;
    subnormal_d = subnormal_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (mant_in == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            frac_out_d  = '0;
            exp_out_d   = '0;
            shift_amt_d = '0;
            zero_d      = 1'b1;
            subnormal_d = 1'b0;
          end else begin
            state_d = SHIFT;
            work_d  = mant_in;
            e_d     = exp_in;
            cnt_d   = '0;
          end
        end
      end
      SHIFT: begin
        // Leading-one check wins over the exponent floor when both hold.
        if (work_q[WIDTH-1]) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          frac_out_d  = work_q[WIDTH-2 -: FRAC_W];
          exp_out_d   = e_q;
          shift_amt_d = cnt_q;
          zero_d      = 1'b0;
          subnormal_d = 1'b0;
        end else if (e_q <= EXP_W'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          frac_out_d  = work_q[WIDTH-1 -: FRAC_W];
          exp_out_d   = '0;
          shift_amt_d = cnt_q;
          zero_d      = 1'b0;
          subnormal_d = 1'b1;
        end else begin
          work_d = {work_q[WIDTH-2:0], 1'b0};
          e_d    = e_q - EXP_W'(1);
          cnt_d  = cnt_q + 8'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      e_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      frac_out_q  <= '0;
      exp_out_q   <= '0;
      shift_amt_q <= '0;
      zero_q      <= 1'b0;
      subnormal_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      e_q         <= e_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      frac_out_q  <= frac_out_d;
      exp_out_q   <= exp_out_d;
      shift_amt_q <= shift_amt_d;
      zero_q      <= zero_d;
      subnormal_q <= subnormal_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign frac_out  = frac_out_q;
  assign exp_out   = exp_out_q;
  assign shift_amt = shift_amt_q;
  assign zero      = zero_q;
  assign subnormal = subnormal_q;

endmodule

`default_nettype wire

// File: tb/tb_left_shift_normalizer.sv
`default_nettype none
// ---- tb_left_shift_normalizer: vector table, corner sequences and random ops vs a reference model ----

module tb_left_shift_normalizer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] mant_in;
  logic [7:0]  exp_in;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] frac_out;
  logic [7:0]  exp_out;
  logic [7:0]  shift_amt;
  logic        zero;
  logic        subnormal;

  int total = 0;
  int bad   = 0;

  left_shift_normalizer #(.WIDTH(48), .FRAC_W(23), .EXP_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mant_in   (mant_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frac_out  (frac_out),
    .exp_out   (exp_out),
    .shift_amt (shift_amt),
    .zero      (zero),
    .subnormal (subnormal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] m;
    logic [7:0]  e;
    logic [22:0] f;
    logic [7:0]  eo;
    logic [7:0]  sa;
    logic        z;
    logic        s;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: locate the leading one, then shift as far as the exponent floor allows.
  function automatic void model(input logic [47:0] m, input logic [7:0] e,
                                output logic [22:0] f, output logic [7:0] eo,
                                output logic [7:0] sa, output logic z,
                                output logic s, output int lat);
    int p;
    int lz;
    int allowed;
    logic [47:0] sh;
    p = -1;
    for (int i = 0; i < 48; i++) if (m[i]) p = i;
    if (p < 0) begin
      f = '0; eo = '0; sa = '0; z = 1'b1; s = 1'b0; lat = 1;
      return;
    end
    z = 1'b0;
    lz = 47 - p;
    allowed = (int'(e) > 1) ? int'(e) - 1 : 0;
    if (lz <= allowed) begin
      sh = m << lz;
      f = sh[46:24]; eo = 8'(int'(e) - lz); sa = 8'(lz); s = 1'b0; lat = lz + 2;
    end else begin
      sh = m << allowed;
      f = sh[47:25]; eo = '0; sa = 8'(allowed); s = 1'b1; lat = allowed + 2;
    end
  endfunction

  task automatic run_op(input logic [47:0] m, input logic [7:0] e, input bit release_out,
                        output int lat, output logic [22:0] f, output logic [7:0] eo,
                        output logic [7:0] sa, output logic z, output logic s);
    @(negedge clk);
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    mant_in  = m;
    exp_in   = e;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", 64'(out_valid), 64'd1);
    f  = frac_out;
    eo = exp_out;
    sa = shift_amt;
    z  = zero;
    s  = subnormal;
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("out_valid_after_handshake", 64'(out_valid), 64'd0);
      check("in_ready_after_handshake", 64'(in_ready), 64'd1);
    end
  endtask

  task automatic check_result(input string tag, input vec_t v, input int lat,
                              input logic [22:0] f, input logic [7:0] eo,
                              input logic [7:0] sa, input logic z, input logic s);
    check({tag, "_frac"},      64'(f),   64'(v.f));
    check({tag, "_exp"},       64'(eo),  64'(v.eo));
    check({tag, "_shift"},     64'(sa),  64'(v.sa));
    check({tag, "_zero"},      64'(z),   64'(v.z));
    check({tag, "_subnormal"}, 64'(s),   64'(v.s));
    check({tag, "_latency"},   64'(lat), 64'(v.lat));
  endtask

  initial begin
    int          lat;
    logic [22:0] f;
    logic [7:0]  eo, sa;
    logic        z, s;
    vec_t        v;

    vecs[0] = '{48'h8000_0000_0000, 8'd130, 23'h000000, 8'd130, 8'd0,  1'b0, 1'b0, 2};
    vecs[1] = '{48'h0000_0100_0000, 8'd100, 23'h000000, 8'd77,  8'd23, 1'b0, 1'b0, 25};
    vecs[2] = '{48'h0000_0000_0000, 8'd90,  23'h000000, 8'd0,   8'd0,  1'b1, 1'b0, 1};
    vecs[3] = '{48'h0080_0000_0000, 8'd5,   23'h040000, 8'd0,   8'd4,  1'b0, 1'b1, 6};
    vecs[4] = '{48'h0000_0000_0001, 8'd200, 23'h000000, 8'd153, 8'd47, 1'b0, 1'b0, 49};
    vecs[5] = '{48'h0000_0000_0001, 8'd0,   23'h000000, 8'd0,   8'd0,  1'b0, 1'b1, 2};
    vecs[6] = '{48'h4000_0000_0000, 8'd1,   23'h200000, 8'd0,   8'd0,  1'b0, 1'b1, 2};
    vecs[7] = '{48'h2000_0000_0000, 8'd3,   23'h000000, 8'd1,   8'd2,  1'b0, 1'b0, 4};
    vecs[8] = '{48'hC000_0000_0001, 8'd10,  23'h400000, 8'd10,  8'd0,  1'b0, 1'b0, 2};
    vecs[9] = '{48'h8000_0000_0000, 8'd1,   23'h000000, 8'd1,   8'd0,  1'b0, 1'b0, 2};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mant_in   = '0;
    exp_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {out_valid, frac_out, exp_out, shift_amt, zero, subnormal}, '0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].m, vecs[i].e, 1'b1, lat, f, eo, sa, z, s);
      check_result($sformatf("vec%0d", i), vecs[i], lat, f, eo, sa, z, s);
    end

    // Backpressure: result held while a stray in_valid pulse is ignored.
    run_op(vecs[0].m, vecs[0].e, 1'b0, lat, f, eo, sa, z, s);
    check_result("hold", vecs[0], lat, f, eo, sa, z, s);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i == 2);
      mant_in  = vecs[1].m;
      exp_in   = vecs[1].e;
      @(posedge clk);
      #1;
      check("hold_stable", {out_valid, frac_out, exp_out, shift_amt, zero, subnormal, in_ready},
            {1'b1, 23'h0, 8'd130, 8'd0, 1'b0, 1'b0, 1'b0});
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("hold_release_valid", 64'(out_valid), 64'd0);
    check("hold_release_ready", 64'(in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("pulse_not_queued", {out_valid, in_ready}, 2'b01);

    // Reset in the middle of a long shift sequence.
    @(negedge clk);
    mant_in  = vecs[1].m;
    exp_in   = vecs[1].e;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("midshift_busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("midshift_reset_outputs", {out_valid, frac_out, exp_out, shift_amt, zero, subnormal}, '0);
    check("midshift_reset_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("midshift_no_output", 64'(out_valid), 64'd0);
    run_op(vecs[0].m, vecs[0].e, 1'b1, lat, f, eo, sa, z, s);
    check_result("post_reset", vecs[0], lat, f, eo, sa, z, s);

    for (int i = 0; i < 200; i++) begin
      logic [47:0] m;
      logic [7:0]  e;
      m = {$urandom(), $urandom()} >> $urandom_range(0, 47);
      if ($urandom_range(0, 15) == 0) m = '0;
      e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 255));
      v.m = m;
      v.e = e;
      model(m, e, v.f, v.eo, v.sa, v.z, v.s, v.lat);
      run_op(m, e, 1'b1, lat, f, eo, sa, z, s);
      check_result($sformatf("rand%0d", i), v, lat, f, eo, sa, z, s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
